// File: rtl/sram_controller.sv
// sram_controller: runs one 32-bit MEM-stage load/store as two 16-bit accesses to an asynchronous SRAM
//
// Optional feature: define SRAM_ADDR_CHECK_EN to reject requests outside the SRAM window.
// A rejected request goes straight to DONE, issues no strobes, and a rejected read returns 0.
//
// Parameters:
//   WAIT_CYCLES  cycles per half-word phase (1..15)
//   BASE_ADDR    byte address mapped to SRAM half-word 0
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rd_en, wr_en        load / store request (store wins if both are high)
//   address             byte address; bits [1:0] are ignored
//   write_data          store data
//   read_data           load result, held until the next completed read
//   ready               idle or done; pipeline freeze = ~ready
//   sram_addr           SRAM half-word address
//   sram_dq_out         data driven to SRAM
//   sram_dq_oe          tristate enable for sram_dq_out
//   sram_dq_in          data returned by SRAM
//   sram_we_n           write strobe, active-low
//   sram_oe_n           output enable, active-low
module sram_controller #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    state_t      state, state_n;
    logic [3:0]  wcnt, wcnt_n;
    logic [16:0] word, word_c, new_word;
    logic [31:0] wdata, wdata_c;
    logic [15:0] rbuf;
    logic        is_wr, wr_c, req, accept, last, in_range, phase_n, drive_wr;

    assign req      = rd_en | wr_en;
    assign accept   = (state == IDLE) && req;
    assign last     = wcnt == 4'(WAIT_CYCLES - 1);
    assign new_word = 17'((address - BASE_ADDR) >> 2);
`ifdef SRAM_ADDR_CHECK_EN
    assign in_range = (address >= BASE_ADDR) && ((address - BASE_ADDR) < 32'h0008_0000);
`else
    assign in_range = 1'b1;
`endif
    assign ready    = !((state == LOW) || (state == HIGH) || accept);

    // The values about to be used: freshly latched on acceptance, otherwise the held copies.
    assign word_c   = accept ? new_word : word;
    assign wdata_c  = accept ? write_data : wdata;
    assign wr_c     = accept ? wr_en : is_wr;
    assign phase_n  = (state_n == LOW) || (state_n == HIGH);
    assign drive_wr = phase_n && wr_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = '0;
        case (state)
            IDLE: state_n = req ? (in_range ? LOW : DONE) : IDLE;
            LOW: begin
                state_n = last ? HIGH : LOW;
                wcnt_n  = last ? 4'd0 : wcnt + 4'd1;
            end
            HIGH: begin
                state_n = last ? DONE : HIGH;
                wcnt_n  = last ? 4'd0 : wcnt + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // SRAM-side outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word        <= '0;
            wdata       <= '0;
            is_wr       <= 1'b0;
            rbuf        <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            word        <= word_c;
            wdata       <= wdata_c;
            is_wr       <= wr_c;
            sram_addr   <= phase_n ? {word_c, state_n == HIGH} : sram_addr;
            sram_dq_out <= drive_wr ? (state_n == HIGH ? wdata_c[31:16] : wdata_c[15:0]) : sram_dq_out;
            sram_dq_oe  <= drive_wr;
            sram_we_n   <= !drive_wr;
            sram_oe_n   <= !(phase_n && !wr_c);
            if (state == LOW && last && !is_wr)
                rbuf <= sram_dq_in;
            // The final HIGH cycle is also the edge that enters DONE.
            if (state == HIGH && last && !is_wr)
                read_data <= {sram_dq_in, rbuf};
`ifdef SRAM_ADDR_CHECK_EN
            if (accept && !in_range && !wr_en)
                read_data <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of sram_controller at WAIT_CYCLES 2 and 1
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          oe_cnt = 0;
    int          lo;

    logic        rd0, wr0, rdy0, oe0, we0n, oen0;
    logic [31:0] addr0, wd0, rdata0;
    logic [17:0] sa0;
    logic [15:0] dqo0, dqi0;
    logic        rd1, wr1, rdy1, oe1, we1n, oen1;
    logic [31:0] addr1, wd1, rdata1;
    logic [17:0] sa1;
    logic [15:0] dqo1, dqi1;

    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];
    logic        pre_en;
    logic [5:0]  pre_addr;
    logic [15:0] pre_data;

    sram_controller #(.WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr0), .write_data(wd0),
        .read_data(rdata0), .ready(rdy0), .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_oe(oe0),
        .sram_dq_in(dqi0), .sram_we_n(we0n), .sram_oe_n(oen0)
    );

    sram_controller #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1), .write_data(wd1),
        .read_data(rdata1), .ready(rdy1), .sram_addr(sa1), .sram_dq_out(dqo1), .sram_dq_oe(oe1),
        .sram_dq_in(dqi1), .sram_we_n(we1n), .sram_oe_n(oen1)
    );

    always #5 clk = ~clk;

    assign dqi0 = mem0[sa0[5:0]];
    assign dqi1 = mem1[sa1[5:0]];

    always @(posedge clk) begin
        if (pre_en)
            mem0[pre_addr] <= pre_data;
        else if (!we0n)
            mem0[sa0[5:0]] <= dqo0;
        if (!we1n)
            mem1[sa1[5:0]] <= dqo1;
        if (!oen0)
            oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [15:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    // Issue one request from an IDLE cycle, count cycles with ready low, drop it at DONE.
    task automatic op(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                      output int n);
        if (u == 0) begin
            rd0 = !w; wr0 = w; addr0 = a; wd0 = d;
        end else begin
            rd1 = !w; wr1 = w; addr1 = a; wd1 = d;
        end
        #1;
        n = 0;
        while (!(u == 0 ? rdy0 : rdy1) && n < 20) begin
            n++;
            step();
        end
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
        step();
    endtask

    initial begin
        rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        #2 rst = 1'b1;
        #1;
        check("rst ready", rdy0, 1);
        check("rst we_n", we0n, 1);
        check("rst oe_n", oen0, 1);
        check("rst dq_oe", oe0, 0);
        check("rst read_data", rdata0, 0);
        check("rst sram_addr", sa0, 0);
        preload(0, 16'hBEEF);
        preload(1, 16'hDEAD);
        preload(5, 16'h7777);
        rst = 1'b0;
        step();

        rd0 = 1; addr0 = 1024;
        #1 check("rd t ready", rdy0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("rd c%0d ready", i), rdy0, 0);
            check($sformatf("rd c%0d addr", i), sa0, i <= 2 ? 0 : 1);
            check($sformatf("rd c%0d oe_n", i), oen0, 0);
            check($sformatf("rd c%0d we_n", i), we0n, 1);
        end
        step();
        check("rd done ready", rdy0, 1);
        check("rd done data", rdata0, 32'hDEADBEEF);
        check("rd done oe_n", oen0, 1);
        rd0 = 0;
        step();

        wr0 = 1; addr0 = 1028; wd0 = 32'h12345678;
        #1 check("wr t ready", rdy0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("wr c%0d ready", i), rdy0, 0);
            check($sformatf("wr c%0d addr", i), sa0, i <= 2 ? 2 : 3);
            check($sformatf("wr c%0d dq", i), dqo0, i <= 2 ? 16'h5678 : 16'h1234);
            check($sformatf("wr c%0d we_n", i), we0n, 0);
            check($sformatf("wr c%0d dq_oe", i), oe0, 1);
            check($sformatf("wr c%0d oe_n", i), oen0, 1);
        end
        step();
        check("wr done ready", rdy0, 1);
        check("wr done we_n", we0n, 1);
        check("wr keeps read_data", rdata0, 32'hDEADBEEF);
        check("wr mem lo", mem0[2], 16'h5678);
        check("wr mem hi", mem0[3], 16'h1234);
        wr0 = 0;
        step();

        wr0 = 1; addr0 = 1032; wd0 = 32'h11112222;
        step(); step(); step();
        check("abort high we_n", we0n, 0);
        check("abort high addr", sa0, 5);
        #2 rst = 1'b1; wr0 = 0;
        #1;
        check("abort we_n", we0n, 1);
        check("abort dq_oe", oe0, 0);
        check("abort ready", rdy0, 1);
        check("abort read_data", rdata0, 0);
        #1 rst = 1'b0;
        step();
        check("abort mem lo", mem0[4], 16'h2222);
        check("abort mem hi", mem0[5], 16'h7777);
        check("abort idle", rdy0, 1);
        op(0, 0, 1024, 0, lo);
        check("post-abort rd lo", lo, 5);
        check("post-abort rd data", rdata0, 32'hDEADBEEF);

        op(1, 1, 1032, 32'hA5A5A5A5, lo);
        check("b2b wr lo", lo, 3);
        op(1, 0, 1032, 0, lo);
        check("b2b rd lo", lo, 3);
        check("b2b rd data", rdata1, 32'hA5A5A5A5);
        op(1, 1, 1036, 32'hCAFE0123, lo);
        check("w1 wr lo", lo, 3);
        op(1, 0, 1036, 0, lo);
        check("w1 rd data", rdata1, 32'hCAFE0123);
        check("w1 mem lo", mem1[6], 16'h0123);

`ifdef SRAM_ADDR_CHECK_EN
        begin
            int c;
            c = oe_cnt;
            op(0, 0, 512, 0, lo);
            check("oor lo", lo, 1);
            check("oor read_data", rdata0, 0);
            check("oor no oe_n", oe_cnt, c);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM. It accepts one 32-bit read or write per request and performs it as two half-word SRAM accesses, each stretched over a parameterised number of wait cycles. It drives `ready` low while the access is in flight; the top level derives the pipeline `freeze` as the inverse of `ready`. It is instantiated beside MEM_Stage and feeds MEM_Stage_Reg.

## Interface
- `WAIT_CYCLES`, default 2: cycles per half-word phase; legal range 1–15.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM half-word 0.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `rd_en`  in  1  read request from the MEM stage.
- `wr_en`  in  1  write request from the MEM stage.
- `address`  in  32  byte address, the ALU result.
- `write_data`  in  32  store data, the Rm value.
- `read_data`  out  32  load result.
- `ready`  out  1  transfer complete or idle; pipeline freeze = ~ready.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_dq_out`  out  16  data driven to SRAM.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_out`.
- `sram_dq_in`  in  16  data returned from SRAM.
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- FSM states: IDLE, LOW, HIGH, DONE. An internal `wcnt` (4 bits) counts cycles within a phase.
- **IDLE**
  - If `wr_en | rd_en`: latch the word address, `write_data` and the op, then go to LOW with `wcnt` = 0.
  - If both `wr_en` and `rd_en` are high, the op is a write.
- **Address mapping:** word = (`address` − `BASE_ADDR`) >> 2, truncated to 17 bits. `address[1:0]` is ignored.
  - LOW phase: `sram_addr` = {word, 0}, data bits [15:0].
  - HIGH phase: `sram_addr` = {word, 1}, data bits [31:16].
- **LOW / HIGH phases**
  - Each phase lasts exactly `WAIT_CYCLES` cycles. `wcnt` increments each cycle and clears on phase exit.
  - Write phase: `sram_dq_oe` = 1, `sram_we_n` = 0, `sram_oe_n` = 1, `sram_dq_out` = selected half.
  - Read phase: `sram_dq_oe` = 0, `sram_we_n` = 1, `sram_oe_n` = 0. `sram_dq_in` is captured on the final cycle of the phase into the matching half of the read buffer.
- **DONE** lasts one cycle, then returns to IDLE.
  - On a read, `read_data` is updated with the buffer when DONE is entered.
  - On a write, `read_data` holds its previous value.
- Outside active phases: `sram_we_n` = 1, `sram_oe_n` = 1, `sram_dq_oe` = 0, and `sram_addr` holds its last value.
- **`ready`** (combinational): 0 when (state ≠ IDLE and state ≠ DONE), or when (state = IDLE and a request is present). Otherwise 1.
- A request deasserted mid-transfer is ignored and the transfer completes; the frozen pipeline holds the request stable in any case.
- **Reset** (asynchronous, any state):
  - State goes to IDLE, `wcnt` = 0.
  - `read_data` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `sram_dq_oe` = 0, `sram_we_n` = 1, `sram_oe_n` = 1.
  - Any in-flight write is abandoned with no further strobes.

## Timing
- Request present in IDLE at cycle t:
  - `ready` = 0 for cycles t .. t+2·W, where W = `WAIT_CYCLES`.
  - `ready` = 1 at cycle t+2·W+1 (DONE); the pipeline advances on that edge.
- LOW occupies cycles t+1 .. t+W. HIGH occupies cycles t+W+1 .. t+2·W.
- `read_data` is valid from cycle t+2·W+1 and stays stable until the next completed read.
- **Back-to-back:** a new request can be accepted in the IDLE cycle following DONE. Minimum request-to-request spacing is 2·W+2 cycles.
- All SRAM-side outputs are decoded from registered state, latched address and latched data; they are glitch-free within a cycle.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined:
  - A request whose `address` is < `BASE_ADDR` or ≥ `BASE_ADDR` + 2^19 bytes goes IDLE→DONE directly.
  - No SRAM strobes are issued.
  - A read returns `read_data` = 0.
  - `ready` is low for 1 cycle.
- `SRAM_ADDR_CHECK_EN` undefined: no range check; every address is mapped with truncation.

## Test plan
- **Reset:** assert `rst` mid-cycle → immediately `ready`=1, `sram_we_n`=1, `sram_oe_n`=1, `sram_dq_oe`=0, `read_data`=0.
- **Read, W=2:** `rd_en`=1, `address`=1024, SRAM returns 0xBEEF at half-address 0 and 0xDEAD at half-address 1 → `ready` low 5 cycles, `sram_addr` 0 then 1 for 2 cycles each, `read_data`=0xDEADBEEF at DONE.
- **Write, W=2:** `wr_en`=1, `address`=1028, data 0x12345678 → `sram_addr`=2 with dq 0x5678, then `sram_addr`=3 with dq 0x1234. `sram_we_n` is low for 2 cycles in each phase. `read_data` is unchanged.
- **Reset mid-write:** `rst` pulsed in the 1st HIGH cycle → `sram_we_n`=1 and `sram_dq_oe`=0 at once. State is IDLE afterwards. A following read of 1024 completes normally.
- **Back-to-back:** write 0xA5A5A5A5 to 1032, then a read of 1032 held from the next IDLE, W=1 → each op holds `ready` low 3 cycles, and the read returns 0xA5A5A5A5.
- **With `SRAM_ADDR_CHECK_EN`:** read `address`=512 → `ready` low 1 cycle, no `sram_oe_n` pulse, `read_data`=0.
